// File: rtl/soc_system_onchip_mem_streamer_if.sv
// Bus bundle for the on-chip memory streamer: the Avalon-MM read port toward
// the 12288x32 memory and the Avalon-ST source port toward the consumer.
interface soc_system_onchip_mem_streamer_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_write;
  logic [3:0]        m_byteenable;
  logic [DATA_W-1:0] m_readdata;

  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_startofpacket;
  logic              src_endofpacket;

  // Streamer side: issues memory reads and sources the packet
  modport master (
    output m_address, m_chipselect, m_write, m_byteenable,
    input  m_readdata,
    output src_data, src_valid, src_startofpacket, src_endofpacket,
    input  src_ready
  );

  // Memory and stream-consumer side
  modport slave (
    input  m_address, m_chipselect, m_write, m_byteenable,
    output m_readdata,
    input  src_data, src_valid, src_startofpacket, src_endofpacket,
    output src_ready
  );
endinterface

// File: rtl/soc_system_onchip_mem_streamer.sv
// Avalon-MM read master that streams a block of on-chip memory words out as
// one Avalon-ST packet. A small skid FIFO catches the 1-cycle read latency;
// reads are only issued when the FIFO is guaranteed to have room for them.
module soc_system_onchip_mem_streamer #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int MEM_WORDS  = 12288,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  soc_system_onchip_mem_streamer_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_W:0]   MEM_WORDS_W = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [ADDR_W:0]   ONE_W       = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(MEM_WORDS - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR    = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]    DEPTH_W     = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              first;

  // Packet tags travelling with the read issued this cycle
  logic              cs_sop;
  logic              cs_eop;

  // Read-return stage: m_readdata is valid while ret_valid is high
  logic              ret_valid;
  logic              ret_sop;
  logic              ret_eop;

  logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_sop;
  logic [FIFO_DEPTH-1:0] fifo_eop;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             issue;
  logic             last_pop;
  logic [CNT_W:0]   credit_sum;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty = (fifo_count == '0);
  assign push       = ret_valid;
  assign pop        = !fifo_empty && bus.src_ready;

  // Words already stored, plus the one returning now, plus the read on the bus
  assign credit_sum = {1'b0, fifo_count}
                    + {{CNT_W{1'b0}}, ret_valid}
                    + {{CNT_W{1'b0}}, bus.m_chipselect};
  assign issue      = (state == RUN) && (credit_sum < DEPTH_W);

  // The eop word leaving with nothing left behind it finishes the packet
  assign last_pop   = pop && fifo_eop[rd_ptr] && (fifo_count == CNT_W'(1))
                    && !ret_valid && !bus.m_chipselect;

  assign busy                  = (state != IDLE);
  assign bus.m_write           = 1'b0;
  assign bus.m_byteenable      = 4'hF;
  assign bus.src_valid         = !fifo_empty;
  assign bus.src_data          = fifo_empty ? '0 : fifo_data[rd_ptr];
  assign bus.src_startofpacket = !fifo_empty && fifo_sop[rd_ptr];
  assign bus.src_endofpacket   = !fifo_empty && fifo_eop[rd_ptr];

  // FIFO storage; pointers and count live in the control block below
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.m_readdata;
      fifo_sop[wr_ptr]  <= ret_sop;
      fifo_eop[wr_ptr]  <= ret_eop;
    end
  end

  // Command FSM, read issue, read-return pipeline and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      addr             <= '0;
      remaining        <= '0;
      first            <= 1'b0;
      cs_sop           <= 1'b0;
      cs_eop           <= 1'b0;
      ret_valid        <= 1'b0;
      ret_sop          <= 1'b0;
      ret_eop          <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_count       <= '0;
      done             <= 1'b0;
      err              <= 1'b0;
      bus.m_chipselect <= 1'b0;
      bus.m_address    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (busy && abort) begin
        state            <= IDLE;
        wr_ptr           <= '0;
        rd_ptr           <= '0;
        fifo_count       <= '0;
        ret_valid        <= 1'b0;
        bus.m_chipselect <= 1'b0;
      end else begin
        ret_valid        <= bus.m_chipselect;
        ret_sop          <= cs_sop;
        ret_eop          <= cs_eop;
        bus.m_chipselect <= issue;

        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CNT_W'(1);
          2'b01:   fifo_count <= fifo_count - CNT_W'(1);
          default: fifo_count <= fifo_count;
        endcase

        case (state)
          IDLE: begin
            if (start) begin
              if (({1'b0, base_addr} >= MEM_WORDS_W) || (length > MEM_WORDS_W)) begin
                err <= 1'b1;
              end else if (length == '0) begin
                done <= 1'b1;
              end else begin
                addr      <= base_addr;
                remaining <= length;
                first     <= 1'b1;
                state     <= RUN;
              end
            end
          end
          RUN: begin
            if (issue) begin
              bus.m_address <= addr;
              cs_sop        <= first;
              cs_eop        <= (remaining == ONE_W);
              first         <= 1'b0;
              addr          <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
              remaining     <= remaining - ONE_W;
              if (remaining == ONE_W) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (last_pop) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_soc_system_onchip_mem_streamer.sv
// Directed bench for the on-chip memory streamer. The memory model returns
// 32'hA000_0000 + address one cycle after each chipselect cycle.
module tb_soc_system_onchip_mem_streamer;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 32;
  localparam int MEM_WORDS  = 12288;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   length = '0;
  logic              busy;
  logic              done;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;
  int cs_total = 0;

  soc_system_onchip_mem_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  soc_system_onchip_mem_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .abort(abort), .busy(busy), .done(done), .err(err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory model with fixed 1-cycle read latency; junk when not reading
  always @(posedge clk) begin
    if (bus.m_chipselect) begin
      bus.m_readdata <= 32'hA000_0000 + 32'(bus.m_address);
      cs_total       <= cs_total + 1;
    end else begin
      bus.m_readdata <= 32'hDEAD_BEEF;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one edge; returns in cycle 0
  task automatic issue_cmd(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    bus.src_ready = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    n_tests++;
    if ({busy, done, err, bus.m_chipselect, bus.src_valid, bus.src_startofpacket,
         bus.src_endofpacket, bus.m_write} !== 8'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b expected 00000000", {busy, done, err,
               bus.m_chipselect, bus.src_valid, bus.src_startofpacket, bus.src_endofpacket, bus.m_write});
    end
    n_tests++;
    if (bus.m_address !== '0 || bus.src_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_buses: got addr %h data %h expected 0 0", bus.m_address, bus.src_data);
    end
    n_tests++;
    if (bus.m_byteenable !== 4'hF) begin
      n_fail++;
      $display("[TB] FAIL reset_byteenable: got %h expected f", bus.m_byteenable);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic exp_cs, exp_v;
    bus.src_ready = 1'b1;
    issue_cmd('0, (ADDR_W+1)'(4));
    for (int c = 0; c <= 8; c++) begin
      exp_cs = (c >= 1 && c <= 4);
      exp_v  = (c >= 3 && c <= 6);
      n_tests++;
      if (bus.m_chipselect !== exp_cs || (exp_cs && bus.m_address !== ADDR_W'(c - 1))) begin
        n_fail++;
        $display("[TB] FAIL basic_read c%0d: got cs %b addr %0d expected cs %b addr %0d",
                 c, bus.m_chipselect, bus.m_address, exp_cs, c - 1);
      end
      n_tests++;
      if (bus.src_valid !== exp_v || (exp_v && bus.src_data !== 32'hA000_0000 + 32'(c - 3))) begin
        n_fail++;
        $display("[TB] FAIL basic_data c%0d: got v %b data %h expected v %b data %h",
                 c, bus.src_valid, bus.src_data, exp_v, 32'hA000_0000 + 32'(c - 3));
      end
      n_tests++;
      if ({bus.src_startofpacket, bus.src_endofpacket} !== {c == 3, c == 6}) begin
        n_fail++;
        $display("[TB] FAIL basic_sop_eop c%0d: got %b%b expected %b%b", c,
                 bus.src_startofpacket, bus.src_endofpacket, c == 3, c == 6);
      end
      n_tests++;
      if (done !== (c == 7) || busy !== (c <= 6)) begin
        n_fail++;
        $display("[TB] FAIL basic_status c%0d: got done %b busy %b expected done %b busy %b",
                 c, done, busy, c == 7, c <= 6);
      end
      step();
    end
    n_tests++;
    if (bus.m_write !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_write: got %b expected 0", bus.m_write);
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_a [4];
    exp_a[0] = ADDR_W'(12286);
    exp_a[1] = ADDR_W'(12287);
    exp_a[2] = ADDR_W'(0);
    exp_a[3] = ADDR_W'(1);
    bus.src_ready = 1'b1;
    issue_cmd(ADDR_W'(12286), (ADDR_W+1)'(4));
    for (int c = 0; c <= 7; c++) begin
      if (c >= 1 && c <= 4) begin
        n_tests++;
        if (bus.m_chipselect !== 1'b1 || bus.m_address !== exp_a[c-1]) begin
          n_fail++;
          $display("[TB] FAIL wrap_addr c%0d: got cs %b addr %0d expected cs 1 addr %0d",
                   c, bus.m_chipselect, bus.m_address, exp_a[c-1]);
        end
      end
      if (c >= 3 && c <= 6) begin
        n_tests++;
        if (bus.src_valid !== 1'b1 || bus.src_data !== 32'hA000_0000 + 32'(exp_a[c-3])
            || bus.src_endofpacket !== (c == 6)) begin
          n_fail++;
          $display("[TB] FAIL wrap_data c%0d: got v %b data %h eop %b expected v 1 data %h eop %b",
                   c, bus.src_valid, bus.src_data, bus.src_endofpacket,
                   32'hA000_0000 + 32'(exp_a[c-3]), c == 6);
        end
      end
      if (c == 7) begin
        n_tests++;
        if (done !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL wrap_done: got %b expected 1", done);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int got, issued_pre;
    bit popped, done_seen;
    logic pv, pr, ps, pe;
    logic [DATA_W-1:0] pd;
    got = 0; issued_pre = 0; popped = 0; done_seen = 0;
    pv = 1'b0; pr = 1'b0; ps = 1'b0; pe = 1'b0; pd = '0;
    bus.src_ready = 1'b0;
    issue_cmd('0, (ADDR_W+1)'(16));
    for (int c = 0; c < 200 && !done_seen; c++) begin
      bus.src_ready = (c < 10) ? 1'b0 : (((c - 10) % 2) == 0);
      if (bus.m_chipselect && !popped) issued_pre++;
      if (pv && !pr) begin
        n_tests++;
        if (bus.src_valid !== 1'b1 || bus.src_data !== pd
            || bus.src_startofpacket !== ps || bus.src_endofpacket !== pe) begin
          n_fail++;
          $display("[TB] FAIL bp_stable c%0d: got v %b data %h expected v 1 data %h",
                   c, bus.src_valid, bus.src_data, pd);
        end
      end
      if (bus.src_valid && bus.src_ready) begin
        popped = 1;
        n_tests++;
        if (bus.src_data !== 32'hA000_0000 + 32'(got) || bus.src_startofpacket !== (got == 0)
            || bus.src_endofpacket !== (got == 15)) begin
          n_fail++;
          $display("[TB] FAIL bp_word %0d: got data %h sop %b eop %b expected data %h sop %b eop %b",
                   got, bus.src_data, bus.src_startofpacket, bus.src_endofpacket,
                   32'hA000_0000 + 32'(got), got == 0, got == 15);
        end
        got++;
      end
      if (done) done_seen = 1;
      pv = bus.src_valid; pr = bus.src_ready; pd = bus.src_data;
      ps = bus.src_startofpacket; pe = bus.src_endofpacket;
      step();
    end
    n_tests++;
    if (issued_pre > FIFO_DEPTH || issued_pre == 0) begin
      n_fail++;
      $display("[TB] FAIL bp_credit: got %0d reads before first pop expected 1..%0d", issued_pre, FIFO_DEPTH);
    end
    n_tests++;
    if (got != 16 || !done_seen) begin
      n_fail++;
      $display("[TB] FAIL bp_count: got %0d words done %0d expected 16 words done 1", got, done_seen);
    end
  endtask

  task automatic test_commands();
    int cs_before;
    bus.src_ready = 1'b1;
    cs_before = cs_total;
    issue_cmd('0, '0);
    n_tests++;
    if ({done, err, busy} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL len0: got done/err/busy %b expected 100", {done, err, busy});
    end
    step();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL len0_pulse: got done %b expected 0", done);
    end
    issue_cmd(ADDR_W'(MEM_WORDS), (ADDR_W+1)'(4));
    n_tests++;
    if ({done, err, busy} !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL bad_base: got done/err/busy %b expected 010", {done, err, busy});
    end
    step();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bad_base_pulse: got err %b expected 0", err);
    end
    issue_cmd('0, (ADDR_W+1)'(MEM_WORDS + 1));
    n_tests++;
    if ({done, err, busy} !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL bad_len: got done/err/busy %b expected 010", {done, err, busy});
    end
    step();
    step();
    step();
    n_tests++;
    if ((cs_total - cs_before) != 0) begin
      n_fail++;
      $display("[TB] FAIL cmd_no_reads: got %0d reads expected 0", cs_total - cs_before);
    end
  endtask

  task automatic test_start_while_busy();
    int cs_before, got, n_done;
    got = 0; n_done = 0;
    bus.src_ready = 1'b1;
    cs_before = cs_total;
    issue_cmd('0, (ADDR_W+1)'(4));
    for (int c = 0; c < 14; c++) begin
      if (c == 2) begin
        start = 1'b1; base_addr = ADDR_W'(50); length = (ADDR_W+1)'(2);
      end else begin
        start = 1'b0;
      end
      if (bus.src_valid && bus.src_ready) begin
        n_tests++;
        if (bus.src_data !== 32'hA000_0000 + 32'(got)) begin
          n_fail++;
          $display("[TB] FAIL busy_start_word %0d: got %h expected %h", got, bus.src_data,
                   32'hA000_0000 + 32'(got));
        end
        got++;
      end
      if (done) n_done++;
      step();
    end
    start = 1'b0;
    n_tests++;
    if (got != 4 || n_done != 1 || (cs_total - cs_before) != 4 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL busy_start: got words %0d done %0d reads %0d busy %b expected 4 1 4 0",
               got, n_done, cs_total - cs_before, busy);
    end
  endtask

  task automatic test_abort();
    int hs, n_bad, got, n_done;
    hs = 0; n_bad = 0; got = 0; n_done = 0;
    bus.src_ready = 1'b1;
    issue_cmd('0, (ADDR_W+1)'(8));
    for (int c = 0; c < 40 && hs < 3; c++) begin
      if (bus.src_valid && bus.src_ready) hs++;
      if (done) n_bad++;
      step();
    end
    n_tests++;
    if (hs != 3) begin
      n_fail++;
      $display("[TB] FAIL abort_wait: got %0d handshakes expected 3", hs);
    end
    abort = 1'b1;
    bus.src_ready = 1'b0;
    if (done || err) n_bad++;
    step();
    abort = 1'b0;
    n_tests++;
    if ({bus.src_valid, bus.m_chipselect, busy, done, err} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_next: got valid/cs/busy/done/err %b expected 00000",
               {bus.src_valid, bus.m_chipselect, busy, done, err});
    end
    bus.src_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.src_valid || bus.src_endofpacket || done || err) n_bad++;
      step();
    end
    n_tests++;
    if (n_bad != 0) begin
      n_fail++;
      $display("[TB] FAIL abort_quiet: got %0d stray events expected 0", n_bad);
    end
    issue_cmd(ADDR_W'(5), (ADDR_W+1)'(1));
    for (int c = 0; c < 8; c++) begin
      if (bus.src_valid && bus.src_ready) begin
        n_tests++;
        if (bus.src_data !== 32'hA000_0005 || bus.src_startofpacket !== 1'b1
            || bus.src_endofpacket !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL abort_restart_word: got data %h sop %b eop %b expected a0000005 1 1",
                   bus.src_data, bus.src_startofpacket, bus.src_endofpacket);
        end
        got++;
      end
      if (done) n_done++;
      step();
    end
    n_tests++;
    if (got != 1 || n_done != 1) begin
      n_fail++;
      $display("[TB] FAIL abort_restart: got words %0d done %0d expected 1 1", got, n_done);
    end
  endtask

  task automatic test_reset_midop();
    int n_bad, got, n_done;
    n_bad = 0; got = 0; n_done = 0;
    bus.src_ready = 1'b1;
    issue_cmd('0, (ADDR_W+1)'(8));
    for (int c = 0; c < 4; c++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    n_tests++;
    if ({busy, done, err, bus.m_chipselect, bus.src_valid, bus.src_startofpacket,
         bus.src_endofpacket} !== 7'b0 || bus.m_address !== '0 || bus.src_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: got flags %b addr %h data %h expected 0",
               {busy, done, err, bus.m_chipselect, bus.src_valid, bus.src_startofpacket,
                bus.src_endofpacket}, bus.m_address, bus.src_data);
    end
    for (int c = 0; c < 6; c++) begin
      if (done || bus.src_valid || busy) n_bad++;
      step();
    end
    n_tests++;
    if (n_bad != 0) begin
      n_fail++;
      $display("[TB] FAIL midreset_quiet: got %0d stray events expected 0", n_bad);
    end
    issue_cmd(ADDR_W'(20), (ADDR_W+1)'(2));
    for (int c = 0; c < 10; c++) begin
      if (bus.src_valid && bus.src_ready) begin
        n_tests++;
        if (bus.src_data !== 32'hA000_0014 + 32'(got) || bus.src_startofpacket !== (got == 0)
            || bus.src_endofpacket !== (got == 1)) begin
          n_fail++;
          $display("[TB] FAIL midreset_word %0d: got data %h sop %b eop %b expected %h %b %b",
                   got, bus.src_data, bus.src_startofpacket, bus.src_endofpacket,
                   32'hA000_0014 + 32'(got), got == 0, got == 1);
        end
        got++;
      end
      if (done) n_done++;
      step();
    end
    n_tests++;
    if (got != 2 || n_done != 1) begin
      n_fail++;
      $display("[TB] FAIL midreset_restart: got words %0d done %0d expected 2 1", got, n_done);
    end
  endtask

  task automatic test_full_memory();
    int got, n_bad, first_bad, cs_before;
    bit done_seen;
    logic [DATA_W-1:0] exp_d;
    got = 0; n_bad = 0; first_bad = -1; done_seen = 0;
    bus.src_ready = 1'b1;
    cs_before = cs_total;
    issue_cmd(ADDR_W'(100), (ADDR_W+1)'(MEM_WORDS));
    for (int c = 0; c < MEM_WORDS + 50 && !done_seen; c++) begin
      if (bus.src_valid && bus.src_ready) begin
        exp_d = 32'hA000_0000 + 32'((100 + got) % MEM_WORDS);
        if (bus.src_data !== exp_d || bus.src_startofpacket !== (got == 0)
            || bus.src_endofpacket !== (got == MEM_WORDS - 1)) begin
          if (n_bad == 0) first_bad = got;
          n_bad++;
        end
        got++;
      end
      if (done) done_seen = 1;
      step();
    end
    n_tests++;
    if (n_bad != 0) begin
      n_fail++;
      $display("[TB] FAIL full_words: got %0d bad words (first at %0d) expected 0", n_bad, first_bad);
    end
    n_tests++;
    if (got != MEM_WORDS || !done_seen || (cs_total - cs_before) != MEM_WORDS) begin
      n_fail++;
      $display("[TB] FAIL full_count: got words %0d reads %0d done %0d expected %0d %0d 1",
               got, cs_total - cs_before, done_seen, MEM_WORDS, MEM_WORDS);
    end
  endtask

  initial begin
    bus.src_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_commands();
    test_start_while_busy();
    test_abort();
    test_reset_midop();
    test_full_memory();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
